// File: rtl/hdmi_timing_gen_if.sv
// Video timing bus: pattern controls in, timing/pixel stream out.
interface hdmi_timing_gen_if #(
    parameter int unsigned CNT_W   = 10,
    parameter int unsigned COLOR_W = 8
);
    logic [1:0]           mode;
    logic [3*COLOR_W-1:0] solid_rgb;
    logic                 pix_en;
    logic [CNT_W-1:0]     CountX;
    logic [CNT_W-1:0]     CountY;
    logic                 H_sync;
    logic                 V_sync;
    logic                 Draw_enable;
    logic [COLOR_W-1:0]   RED;
    logic [COLOR_W-1:0]   GREEN;
    logic [COLOR_W-1:0]   BLUE;
    logic                 line_start;
    logic                 frame_start;

    // Timing generator side
    modport master (
        input  mode, solid_rgb,
        output pix_en, CountX, CountY, H_sync, V_sync, Draw_enable,
               RED, GREEN, BLUE, line_start, frame_start
    );

    // Video sink side
    modport slave (
        output mode, solid_rgb,
        input  pix_en, CountX, CountY, H_sync, V_sync, Draw_enable,
               RED, GREEN, BLUE, line_start, frame_start
    );
endinterface

// File: rtl/hdmi_timing_gen.sv
// Video timing and test-pattern generator driven by a pixel-rate enable on clk_50.
module hdmi_timing_gen #(
    parameter int unsigned PIX_DIV  = 2,
    parameter int unsigned CNT_W    = 10,
    parameter int unsigned COLOR_W  = 8,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          HS_POL   = 1'b1,
    parameter bit          VS_POL   = 1'b1,
    parameter int unsigned CHK_LOG2 = 5
) (
    input  logic                clk_50,
    input  logic                reset,
    hdmi_timing_gen_if.master   vid
);
    localparam int unsigned H_TOT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;
    localparam int unsigned BAR_W    = H_ACTIVE / 8;
    localparam int unsigned DIV_W    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam int unsigned BAR_PW   = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam int unsigned RGB_W    = 3 * COLOR_W;

    // Reject geometries the counters cannot represent
    if (PIX_DIV < 1 || BAR_W < 1 || CHK_LOG2 >= CNT_W ||
        H_TOT > (2 ** CNT_W) || V_TOT > (2 ** CNT_W)) begin : g_param_err
        $error("hdmi_timing_gen: illegal parameter set");
    end

    logic [DIV_W-1:0]   div_q, div_d;
    logic [CNT_W-1:0]   hx_q, hx_d, vy_q, vy_d;
    logic [BAR_PW-1:0]  bar_pix_q, bar_pix_d;
    logic [2:0]         bar_idx_q, bar_idx_d;
    logic [1:0]         mode_q, mode_d;
    logic [RGB_W-1:0]   solid_q, solid_d;
    logic               pix_en_q, pix_en_d;
    logic [CNT_W-1:0]   countx_q, countx_d, county_q, county_d;
    logic               hs_q, hs_d, vs_q, vs_d, de_q, de_d;
    logic [RGB_W-1:0]   rgb_q, rgb_d;
    logic               line_start_q, line_start_d;
    logic               frame_start_q, frame_start_d;

    logic               pe_c, hx_last_c, vy_last_c, de_c;
    logic [COLOR_W-1:0] red_c, green_c, blue_c;

    // Next-state: divider, raster counters, bar tracker, frame-aligned mode latch, output decode
    always_comb begin
        div_d         = div_q;
        hx_d          = hx_q;
        vy_d          = vy_q;
        bar_pix_d     = bar_pix_q;
        bar_idx_d     = bar_idx_q;
        mode_d        = mode_q;
        solid_d       = solid_q;
        countx_d      = countx_q;
        county_d      = county_q;
        hs_d          = hs_q;
        vs_d          = vs_q;
        de_d          = de_q;
        rgb_d         = rgb_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        red_c         = '0;
        green_c       = '0;
        blue_c        = '0;

        pe_c      = (div_q == DIV_W'(PIX_DIV - 1));
        hx_last_c = (32'(hx_q) == H_TOT - 1);
        vy_last_c = (32'(vy_q) == V_TOT - 1);
        de_c      = (32'(hx_q) < H_ACTIVE) && (32'(vy_q) < V_ACTIVE);
        pix_en_d  = pe_c;
        div_d     = pe_c ? '0 : div_q + DIV_W'(1);

        case (mode_q)
            2'd0: begin
                red_c   = COLOR_W'(vy_q >> 1);
                green_c = COLOR_W'(hx_q);
                blue_c  = COLOR_W'(vy_q);
            end
            2'd1: begin
                red_c   = {COLOR_W{~bar_idx_q[1]}};
                green_c = {COLOR_W{~bar_idx_q[2]}};
                blue_c  = {COLOR_W{~bar_idx_q[0]}};
            end
            2'd2: {red_c, green_c, blue_c} = solid_q;
            default: begin
                red_c   = {COLOR_W{hx_q[CHK_LOG2] ^ vy_q[CHK_LOG2]}};
                green_c = red_c;
                blue_c  = red_c;
            end
        endcase

        if (pe_c) begin
            hx_d = hx_last_c ? '0 : hx_q + CNT_W'(1);
            if (hx_last_c) begin
                vy_d = vy_last_c ? '0 : vy_q + CNT_W'(1);
            end

            // Bar index tracks hx/BAR_W without a divider, clamped at the last bar
            if (hx_last_c) begin
                bar_pix_d = '0;
                bar_idx_d = '0;
            end else if (32'(bar_pix_q) == BAR_W - 1) begin
                bar_pix_d = '0;
                if (bar_idx_q != 3'd7) begin
                    bar_idx_d = bar_idx_q + 3'd1;
                end
            end else begin
                bar_pix_d = bar_pix_q + BAR_PW'(1);
            end

            // Pattern controls only change across the frame boundary
            if (hx_last_c && vy_last_c) begin
                mode_d  = vid.mode;
                solid_d = vid.solid_rgb;
            end

            countx_d      = hx_q;
            county_d      = vy_q;
            de_d          = de_c;
            hs_d          = ((32'(hx_q) >= HS_START) && (32'(hx_q) < HS_END)) ? HS_POL : ~HS_POL;
            vs_d          = ((32'(vy_q) >= VS_START) && (32'(vy_q) < VS_END)) ? VS_POL : ~VS_POL;
            rgb_d         = de_c ? {red_c, green_c, blue_c} : '0;
            line_start_d  = (hx_q == '0);
            frame_start_d = (hx_q == '0) && (vy_q == '0);
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk_50) begin
        if (reset) begin
            div_q         <= '0;
            hx_q          <= '0;
            vy_q          <= '0;
            bar_pix_q     <= '0;
            bar_idx_q     <= '0;
            mode_q        <= vid.mode;
            solid_q       <= vid.solid_rgb;
            pix_en_q      <= 1'b0;
            countx_q      <= '0;
            county_q      <= '0;
            hs_q          <= ~HS_POL;
            vs_q          <= ~VS_POL;
            de_q          <= 1'b0;
            rgb_q         <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            hx_q          <= hx_d;
            vy_q          <= vy_d;
            bar_pix_q     <= bar_pix_d;
            bar_idx_q     <= bar_idx_d;
            mode_q        <= mode_d;
            solid_q       <= solid_d;
            pix_en_q      <= pix_en_d;
            countx_q      <= countx_d;
            county_q      <= county_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            de_q          <= de_d;
            rgb_q         <= rgb_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vid.pix_en      = pix_en_q;
    assign vid.CountX      = countx_q;
    assign vid.CountY      = county_q;
    assign vid.H_sync      = hs_q;
    assign vid.V_sync      = vs_q;
    assign vid.Draw_enable = de_q;
    assign vid.RED         = rgb_q[RGB_W-1 -: COLOR_W];
    assign vid.GREEN       = rgb_q[2*COLOR_W-1 -: COLOR_W];
    assign vid.BLUE        = rgb_q[COLOR_W-1:0];
    assign vid.line_start  = line_start_q;
    assign vid.frame_start = frame_start_q;
endmodule

// File: tb/tb_hdmi_timing_gen.sv
// Bench for hdmi_timing_gen: two geometries checked cycle by cycle against a pixel-index model.
module tb_hdmi_timing_gen;
    typedef struct packed {
        int div, h_act, h_fp, h_sync, h_bp, v_act, v_fp, v_sync, v_bp, chk;
        bit hpol, vpol;
    } geo_t;

    typedef struct packed {
        logic        pix_en, line_start, frame_start, de, hs, vs;
        logic [9:0]  x, y;
        logic [23:0] rgb;
    } vid_t;

    // A: full-width 640 line, short frame; B: tiny raster, pixel every cycle, active-low syncs
    localparam geo_t GEO_A = '{div: 2, h_act: 640, h_fp: 16, h_sync: 96, h_bp: 48,
                               v_act: 10, v_fp: 1, v_sync: 2, v_bp: 1, chk: 2,
                               hpol: 1'b1, vpol: 1'b1};
    localparam geo_t GEO_B = '{div: 1, h_act: 8, h_fp: 2, h_sync: 2, h_bp: 2,
                               v_act: 4, v_fp: 1, v_sync: 1, v_bp: 1, chk: 1,
                               hpol: 1'b0, vpol: 1'b0};

    logic clk = 1'b0;
    logic rst_a, rst_b;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   m_a = 0, m_b = 0;
    logic [1:0]  mode_cur_a, mode_cur_b;
    logic [23:0] solid_cur_a, solid_cur_b;

    hdmi_timing_gen_if #(.CNT_W(10), .COLOR_W(8)) vid_a ();
    hdmi_timing_gen_if #(.CNT_W(10), .COLOR_W(8)) vid_b ();

    hdmi_timing_gen #(
        .PIX_DIV(GEO_A.div), .CNT_W(10), .COLOR_W(8),
        .H_ACTIVE(GEO_A.h_act), .H_FP(GEO_A.h_fp), .H_SYNC(GEO_A.h_sync), .H_BP(GEO_A.h_bp),
        .V_ACTIVE(GEO_A.v_act), .V_FP(GEO_A.v_fp), .V_SYNC(GEO_A.v_sync), .V_BP(GEO_A.v_bp),
        .HS_POL(GEO_A.hpol), .VS_POL(GEO_A.vpol), .CHK_LOG2(GEO_A.chk)
    ) u_dut_a (.clk_50(clk), .reset(rst_a), .vid(vid_a));

    hdmi_timing_gen #(
        .PIX_DIV(GEO_B.div), .CNT_W(10), .COLOR_W(8),
        .H_ACTIVE(GEO_B.h_act), .H_FP(GEO_B.h_fp), .H_SYNC(GEO_B.h_sync), .H_BP(GEO_B.h_bp),
        .V_ACTIVE(GEO_B.v_act), .V_FP(GEO_B.v_fp), .V_SYNC(GEO_B.v_sync), .V_BP(GEO_B.v_bp),
        .HS_POL(GEO_B.hpol), .VS_POL(GEO_B.vpol), .CHK_LOG2(GEO_B.chk)
    ) u_dut_b (.clk_50(clk), .reset(rst_b), .vid(vid_b));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic int h_tot(input geo_t g);
        return g.h_act + g.h_fp + g.h_sync + g.h_bp;
    endfunction

    function automatic int v_tot(input geo_t g);
        return g.v_act + g.v_fp + g.v_sync + g.v_bp;
    endfunction

    // True when, after m clock edges out of reset, the output shows the last pixel of a frame
    function automatic bit shows_frame_last(input geo_t g, input int m);
        int ft;
        ft = h_tot(g) * v_tot(g);
        return (m >= g.div) && (m % g.div == 0) && ((m / g.div - 1) % ft == ft - 1);
    endfunction

    // Expected outputs m edges after reset release: pixel n = m/div-1 in raster order
    function automatic vid_t model_px(input geo_t g, input int m, input logic [1:0] mode,
                                      input logic [23:0] solid);
        vid_t v;
        int   n, x, y, bar;
        v    = '0;
        v.hs = ~g.hpol;
        v.vs = ~g.vpol;
        if (m < g.div) return v;
        n = m / g.div - 1;
        x = n % h_tot(g);
        y = (n / h_tot(g)) % v_tot(g);
        v.pix_en      = (m % g.div == 0);
        v.line_start  = v.pix_en && (x == 0);
        v.frame_start = v.pix_en && (x == 0) && (y == 0);
        v.x  = 10'(x);
        v.y  = 10'(y);
        v.de = (x < g.h_act) && (y < g.v_act);
        v.hs = (x >= g.h_act + g.h_fp && x < g.h_act + g.h_fp + g.h_sync) ? g.hpol : ~g.hpol;
        v.vs = (y >= g.v_act + g.v_fp && y < g.v_act + g.v_fp + g.v_sync) ? g.vpol : ~g.vpol;
        if (v.de) begin
            case (mode)
                2'd0: v.rgb = {8'((y / 2) % 256), 8'(x % 256), 8'(y % 256)};
                2'd1: begin
                    bar = x / (g.h_act / 8);
                    if (bar > 7) bar = 7;
                    case (bar)
                        0: v.rgb = 24'hFFFFFF;
                        1: v.rgb = 24'hFFFF00;
                        2: v.rgb = 24'h00FFFF;
                        3: v.rgb = 24'h00FF00;
                        4: v.rgb = 24'hFF00FF;
                        5: v.rgb = 24'hFF0000;
                        6: v.rgb = 24'h0000FF;
                        default: v.rgb = 24'h000000;
                    endcase
                end
                2'd2: v.rgb = solid;
                default: v.rgb = ((((x >> g.chk) ^ (y >> g.chk)) & 1) == 1) ? 24'hFFFFFF : 24'h0;
            endcase
        end
        return v;
    endfunction

    task automatic check_dut(input string id, input vid_t a, input vid_t e);
        check({id, "_pix_en"}, 64'(a.pix_en), 64'(e.pix_en));
        check({id, "_starts"}, 64'({a.line_start, a.frame_start}), 64'({e.line_start, e.frame_start}));
        check({id, "_pos"}, 64'({a.x, a.y}), 64'({e.x, e.y}));
        check({id, "_sync"}, 64'({a.hs, a.vs}), 64'({e.hs, e.vs}));
        check({id, "_de"}, 64'(a.de), 64'(e.de));
        check({id, "_rgb"}, 64'(a.rgb), 64'(e.rgb));
    endtask

    // Edge counters since reset and the pattern each frame should use
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_a) begin
            m_a <= 0;
            mode_cur_a  <= vid_a.mode;
            solid_cur_a <= vid_a.solid_rgb;
        end else begin
            m_a <= m_a + 1;
            // The last pixel of a frame is blanked, so switching here is invisible until (0,0)
            if (shows_frame_last(GEO_A, m_a + 1)) begin
                mode_cur_a  <= vid_a.mode;
                solid_cur_a <= vid_a.solid_rgb;
            end
        end
        if (rst_b) begin
            m_b <= 0;
            mode_cur_b  <= vid_b.mode;
            solid_cur_b <= vid_b.solid_rgb;
        end else begin
            m_b <= m_b + 1;
            if (shows_frame_last(GEO_B, m_b + 1)) begin
                mode_cur_b  <= vid_b.mode;
                solid_cur_b <= vid_b.solid_rgb;
            end
        end
    end

    int last_pe_a = -1, last_ls_a = -1, last_fs_a = -1, last_fs_b = -1, hs_cnt_a = 0;

    // Compare every cycle at the falling edge, plus period and sync-width measurements
    always @(negedge clk) begin
        vid_t act_a, act_b;
        act_a = '{pix_en: vid_a.pix_en, line_start: vid_a.line_start, frame_start: vid_a.frame_start,
                  de: vid_a.Draw_enable, hs: vid_a.H_sync, vs: vid_a.V_sync, x: vid_a.CountX,
                  y: vid_a.CountY, rgb: {vid_a.RED, vid_a.GREEN, vid_a.BLUE}};
        act_b = '{pix_en: vid_b.pix_en, line_start: vid_b.line_start, frame_start: vid_b.frame_start,
                  de: vid_b.Draw_enable, hs: vid_b.H_sync, vs: vid_b.V_sync, x: vid_b.CountX,
                  y: vid_b.CountY, rgb: {vid_b.RED, vid_b.GREEN, vid_b.BLUE}};
        check_dut("a", act_a, model_px(GEO_A, m_a, mode_cur_a, solid_cur_a));
        check_dut("b", act_b, model_px(GEO_B, m_b, mode_cur_b, solid_cur_b));

        if (m_a == 0) begin
            last_pe_a = -1;
            last_ls_a = -1;
            last_fs_a = -1;
            hs_cnt_a  = 0;
        end else begin
            if (vid_a.pix_en) begin
                if (last_pe_a >= 0) check("a_pix_period", 64'(cyc - last_pe_a), 64'(GEO_A.div));
                last_pe_a = cyc;
            end
            if (vid_a.line_start) begin
                if (last_ls_a >= 0) begin
                    check("a_line_period", 64'(cyc - last_ls_a), 64'(GEO_A.div * h_tot(GEO_A)));
                    check("a_hsync_width", 64'(hs_cnt_a), 64'(GEO_A.h_sync));
                end
                last_ls_a = cyc;
                hs_cnt_a  = 0;
            end
            if (vid_a.pix_en && vid_a.H_sync == GEO_A.hpol) hs_cnt_a++;
            if (vid_a.frame_start) begin
                if (last_fs_a >= 0)
                    check("a_frame_period", 64'(cyc - last_fs_a),
                          64'(GEO_A.div * h_tot(GEO_A) * v_tot(GEO_A)));
                last_fs_a = cyc;
            end
        end

        if (m_b == 0) begin
            last_fs_b = -1;
        end else if (vid_b.frame_start) begin
            if (last_fs_b >= 0) check("b_frame_period", 64'(cyc - last_fs_b), 64'(98));
            last_fs_b = cyc;
        end
    end

    // Stimulus: scheduled pattern changes and one mid-frame reset on A, random churn on B
    initial begin
        int t_grad, t_solid, t_chk, t_rst, rst_b_left;
        rst_a = 1'b1;
        rst_b = 1'b1;
        vid_a.mode      = 2'd1;
        vid_a.solid_rgb = 24'($urandom);
        vid_b.mode      = 2'($urandom);
        vid_b.solid_rgb = 24'($urandom);
        rst_b_left = 0;
        t_grad  = 3000 + $urandom_range(0, 2000);
        t_solid = 26000 + $urandom_range(0, 4000);
        t_chk   = 48000 + $urandom_range(0, 1000);
        t_rst   = 50000 + $urandom_range(0, 1500);
        repeat (4) @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;
        for (int c = 0; c < 66000; c++) begin
            @(negedge clk);
            if (c == t_grad) vid_a.mode = 2'd0;
            if (c == t_solid) begin
                vid_a.mode      = 2'd2;
                vid_a.solid_rgb = 24'h123456;
            end
            if (c == t_chk) vid_a.mode = 2'd3;
            rst_a = (c == t_rst);
            if ($urandom_range(0, 39) == 0) begin
                vid_b.mode      = 2'($urandom);
                vid_b.solid_rgb = 24'($urandom);
            end
            if (rst_b_left > 0) rst_b_left--;
            else if ($urandom_range(0, 699) == 0) rst_b_left = $urandom_range(1, 3);
            rst_b = (rst_b_left > 0);
        end
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/hdmi_timing_gen.md
Name: hdmi_timing_gen

Overview:
Parametrised video timing and test-pattern generator for the HDMI transmitter path.
- Runs from the single system clock with an internal pixel-rate enable, so no divided clock is produced.
- Produces programmable-geometry H/V sync, pixel coordinates, data enable and selectable RGB test patterns.
- Sits between the clock/reset logic and the ADV7513 video input; the I2C configuration sequencer runs alongside it, independently.

Parameters:
PIX_DIV, 2, clk_50 cycles per pixel (>=1); 2 gives 25 MHz pixel rate
CNT_W, 10, width of CountX/CountY
COLOR_W, 8, bits per colour channel
H_ACTIVE, 640, active pixels per line
H_FP, 16, horizontal front porch
H_SYNC, 96, horizontal sync width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, active lines
V_FP, 10, vertical front porch
V_SYNC, 2, vertical sync width
V_BP, 33, vertical back porch
HS_POL, 1, 1 = H_sync active-high, 0 = active-low
VS_POL, 1, 1 = V_sync active-high, 0 = active-low
CHK_LOG2, 5, checkerboard square size is 2^CHK_LOG2 pixels

Ports:
clk_50  in  1  system clock; the only clock
reset  in  1  synchronous, active-high reset
mode  in  2  pattern select: 0 gradient, 1 colour bars, 2 solid, 3 checkerboard
solid_rgb  in  3*COLOR_W  solid colour {R,G,B}, used in mode 2
pix_en  out  1  high for one clk_50 cycle when all video outputs have just updated
CountX  out  CNT_W  horizontal position of the current output pixel
CountY  out  CNT_W  vertical position of the current output pixel
H_sync  out  1  horizontal sync, polarity per HS_POL
V_sync  out  1  vertical sync, polarity per VS_POL
Draw_enable  out  1  active-video data enable
RED  out  COLOR_W  red channel
GREEN  out  COLOR_W  green channel
BLUE  out  COLOR_W  blue channel
line_start  out  1  one-cycle pulse, coincident with pix_en, when output CountX==0
frame_start  out  1  one-cycle pulse, coincident with pix_en, when output CountX==0 and CountY==0

Behaviour:
Reset values:
- Clock and reset: one clock, clk_50; reset is synchronous, active-high, port name reset.
- Divider, internal counters, CountX, CountY, RGB, Draw_enable, pix_en, line_start and frame_start all reset to 0.
- H_sync and V_sync reset to their inactive level (~HS_POL, ~VS_POL).
- mode_q loads mode, and solid_q loads solid_rgb, every cycle that reset is high.

Pixel enable:
- The divider counts 0..PIX_DIV-1; the internal enable pe is high when the divider equals PIX_DIV-1.
- The first pe occurs PIX_DIV cycles after reset deasserts.
- With PIX_DIV=1, pe is high every cycle after reset.

Timing:
- H_TOT = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOT is defined likewise.
- Internal counters hx and vy advance on pe. hx wraps at H_TOT-1 to 0; vy increments on each hx wrap and wraps at V_TOT-1.

Output stage (one registered stage, updated on pe):
- All outputs are decoded from the current (hx,vy), so they lag the internal counters by exactly one pixel and are mutually coherent.
- The first pe after reset presents pixel (0,0) with frame_start=1.
- pix_en is pe delayed by one cycle.
- CountX<=hx, CountY<=vy.
- Draw_enable = (hx<H_ACTIVE) && (vy<V_ACTIVE); strict less-than, so x=640 is blanked.
- H_sync is active when H_ACTIVE+H_FP <= hx < H_ACTIVE+H_FP+H_SYNC (defaults: 656..751).
- V_sync is active when V_ACTIVE+V_FP <= vy < V_ACTIVE+V_FP+V_SYNC (defaults: 490..491). V_sync is vertical-only and is not aligned to the H_sync edge.
- RGB = 0 whenever Draw_enable is 0.

Patterns (mode_q):
- 0 gradient: GREEN=hx[COLOR_W-1:0], BLUE=vy[COLOR_W-1:0], RED=(vy>>1)[COLOR_W-1:0].
- 1 colour bars:
  - Bar width BAR_W = H_ACTIVE/8 (integer).
  - Bar index comes from a per-line counter that increments every BAR_W pixels and clamps at 7; no divider.
  - Bar order 0..7: white, yellow, cyan, green, magenta, red, blue, black.
  - "On" channels are all ones; "off" channels are 0.
- 2 solid: RGB = solid_q.
- 3 checkerboard: white (all ones) when hx[CHK_LOG2]^vy[CHK_LOG2]==1, else black.

Mode update:
- mode_q and solid_q update only on the pe where hx==H_TOT-1 and vy==V_TOT-1.
- Mid-frame changes on mode or solid_rgb therefore take effect from the next frame_start and never tear a frame.

Reset and boundaries:
- Reset asserted mid-frame returns everything to reset state on the next clk_50 edge; timing restarts from (0,0).
- Counter widths: CNT_W must hold H_TOT-1 and V_TOT-1; this is checked by elaboration assertion.
- Frame period = H_TOT*V_TOT*PIX_DIV clk_50 cycles (defaults: 840000).

Test Plan:
1. Default params; release reset; count clk_50 cycles between successive frame_start pulses -> exactly 840000; between line_start pulses -> 1600; pix_en period -> 2.
2. Default params; sample at pix_en -> H_sync high for CountX 656..751 only (96 pixels); V_sync high for CountY 490..491 only; Draw_enable high at (639,479), low at (640,0) and (0,480).
3. mode=1 -> at CountX=0 RGB=FF/FF/FF, CountX=80 FF/FF/00, CountX=400 FF/00/00, CountX=639 00/00/00; RGB=0 at CountX=700.
4. mode=0 with mode changed to 2 (solid_rgb=12/34/56) at CountY=100 -> gradient continues until the next frame_start, then every active pixel is 12/34/56; at CountX=300, CountY=7 the gradient reads G=2C, B=07, R=03.
5. Assert reset for 1 cycle at CountX=300, CountY=200 -> outputs return to reset values; H_sync/V_sync go inactive; first pix_en after release shows (0,0) with frame_start=1.
6. PIX_DIV=1, H 8/2/2/2, V 4/1/1/1, HS_POL=0, VS_POL=0 -> frame period 98 cycles; H_sync low exactly at CountX 10..11; V_sync low exactly on CountY 5; pix_en continuously high.
